// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg: shared encodings and defaults for the pipeline hazard controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam logic       ST_RUN             = 1'b0;
  localparam logic       ST_MD              = 1'b1;
  localparam logic [4:0] REG_ZERO           = 5'd0;
  localparam logic [31:0] NOP_INSTR         = 32'h0;
  localparam int         MD_LATENCY_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter: synchronous-reset up counter that sticks at all-ones
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl: load-use / branch / mult-div stall and flush control
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int CNT_W      = 4,
  parameter int PERF_W     = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              id_muldiv,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              if_id_hold,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_flushes
);

  logic             state_q;
  logic             state_d;
  logic [CNT_W-1:0] md_cnt_q;
  logic [CNT_W-1:0] md_cnt_d;
  logic             load_use;

  // Loads targeting $zero never create a dependency.
  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (!branch_taken && !load_use && id_muldiv) begin
          state_d  = ST_MD;
          md_cnt_d = CNT_W'(MD_LATENCY);
        end
      end
      ST_MD: begin
        // A branch here is a protocol error; the countdown is unaffected.
        if (md_cnt_q == CNT_W'(1)) begin
          state_d  = ST_RUN;
          md_cnt_d = '0;
        end else begin
          md_cnt_d = md_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (Reset) begin
      pc_write     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        ST_MD: begin
          pc_write     = 1'b0;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
          if_id_flush  = branch_taken;
        end
        default: begin
          pc_write = 1'b1;
        end
      endcase
    end
  end

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (!pc_write),
    .count (perf_stall_cycles)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (if_id_flush),
    .count (perf_flushes)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl: directed and random checks against a behavioural model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int LAT    = 4;
  localparam int PERF_W = 8;
  localparam int SAT    = (1 << PERF_W) - 1;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [4:0]        id_rs, id_rt, ex_rt;
  logic              id_uses_rt, id_muldiv, ex_mem_read, branch_taken;
  logic              pc_write, if_id_hold, if_id_flush, id_ex_bubble;
  logic [PERF_W-1:0] perf_stall_cycles, perf_flushes;

  int total = 0;
  int bad   = 0;

  // Reference state: remaining mult/div stall cycles and event counts.
  int md_left = 0;
  int stall_n = 0;
  int flush_n = 0;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(4), .PERF_W(PERF_W)) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .id_uses_rt        (id_uses_rt),
    .id_muldiv         (id_muldiv),
    .ex_mem_read       (ex_mem_read),
    .ex_rt             (ex_rt),
    .branch_taken      (branch_taken),
    .pc_write          (pc_write),
    .if_id_hold        (if_id_hold),
    .if_id_flush       (if_id_flush),
    .id_ex_bubble      (id_ex_bubble),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic rd, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic md, input logic br);
    Reset = rst; ex_mem_read = rd; ex_rt = ert; id_rs = rs; id_rt = rt;
    id_uses_rt = urt; id_muldiv = md; branch_taken = br;
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    logic lu;
    logic [3:0] e;
    @(negedge Clk);
    lu = ex_mem_read && (ex_rt != 0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    if (Reset)            e = 4'b0011;
    else if (md_left > 0) e = {1'b0, 1'b1, branch_taken, 1'b1};
    else if (branch_taken) e = 4'b1011;
    else if (lu)          e = 4'b0101;
    else                  e = 4'b1000;
    check("ctrl{pc,hold,flush,bubble}",
          {28'd0, pc_write, if_id_hold, if_id_flush, id_ex_bubble}, {28'd0, e});
    check("perf_stall_cycles", 32'(perf_stall_cycles), 32'(stall_n));
    check("perf_flushes", 32'(perf_flushes), 32'(flush_n));
    if (Reset) begin
      md_left = 0; stall_n = 0; flush_n = 0;
    end else begin
      if (!e[3] && stall_n < SAT) stall_n++;
      if (e[1] && flush_n < SAT) flush_n++;
      if (md_left > 0) md_left--;
      else if (!branch_taken && !lu && id_muldiv) md_left = LAT;
    end
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] r;
    case ($urandom_range(0, 3))
      0: r = 5'd0;
      1: r = 5'd1;
      2: r = 5'd2;
      default: r = 5'd8;
    endcase
    return r;
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("post_reset_stall", 32'(perf_stall_cycles), 32'd0);

    // Load-use on rs, then the same load to $zero.
    drive(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);           step();
    check("lu_stall_count", 32'(perf_stall_cycles), 32'd1);
    drive(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);           step();
    check("zero_reg_no_stall", 32'(perf_stall_cycles), 32'd1);

    // Mult/div occupancy.
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); repeat (5) step();
    check("md_stall_count", 32'(perf_stall_cycles), 32'd5);

    // Branch beats load-use and mult/div.
    drive(0, 1, 5'd3, 5'd3, 5'd0, 0, 1, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);           step();
    check("branch_flush_count", 32'(perf_flushes), 32'd1);
    check("branch_no_md", 32'(perf_stall_cycles), 32'd5);

    // Reset on the second mult/div stall cycle.
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    check("abort_md_counters", 32'(perf_stall_cycles), 32'd0);

    // Continuous load-use drives the stall counter into saturation.
    drive(0, 1, 5'd4, 5'd1, 5'd4, 1, 0, 0);
    repeat (SAT + 3) step();
    check("stall_saturated", 32'(perf_stall_cycles), 32'(SAT));
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();

    // Random traffic, first without reset so counters can saturate.
    for (int i = 0; i < 3000; i++) begin
      drive((i >= 1500) && ($urandom_range(0, 63) == 0),
            $urandom_range(0, 1), pick_reg(), pick_reg(), pick_reg(),
            $urandom_range(0, 1), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and stall controller for the 5-stage pipeline front end.
- Generates PC write-enable, IF/ID hold and flush, and the ID/EX bubble insert.
- Covers three hazard classes: load-use, taken-branch redirect, and multi-cycle mult/div occupancy.
- Sits between the ID/EX decode fields and the PC and IF/ID registers.
- Also keeps two saturating performance counters: stall cycles and flushes.

Parameters:
- MD_LATENCY, 4, number of stall cycles inserted after a mult/div issues; legal range 1..15.
- CNT_W, 4, width of the mult/div countdown counter.
- PERF_W, 16, width of each performance counter.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  instruction in ID reads rt as a source.
- id_muldiv  in  1  instruction in ID is mult/div.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of the load in EX.
- branch_taken  in  1  branch/jump resolved taken this cycle.
- pc_write  out  1  PC load enable.
- if_id_hold  out  1  IF/ID keeps its current instruction.
- if_id_flush  out  1  IF/ID loads 32'h0 (NOP); dominates hold.
- id_ex_bubble  out  1  ID/EX control fields cleared to zero.
- perf_stall_cycles  out  PERF_W  count of cycles with pc_write=0.
- perf_flushes  out  PERF_W  count of cycles with if_id_flush=1.

Behaviour:
- Registered state: 1-bit FSM {ST_RUN, ST_MD}, countdown md_cnt[CNT_W-1:0], and the two performance counters.
- Control outputs are combinational from the registered state and the current inputs, so a hazard takes effect in the same cycle it is visible.
- Reset held: pc_write=0, if_id_hold=0, if_id_flush=1, id_ex_bubble=1.
- On the first edge with Reset=1: state=ST_RUN, md_cnt=0, both performance counters=0.
- Reset mid-stall aborts the stall unconditionally.
- Load-use hazard (lu) = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- ST_RUN, evaluated in priority order:
  1. branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1, hold=0. Stay in ST_RUN; id_muldiv and lu are ignored.
  2. lu: pc_write=0, if_id_hold=1, id_ex_bubble=1. Exactly 1 stall cycle; lu clears naturally once the load moves to MEM. No state change.
  3. id_muldiv: no stall this cycle (pc_write=1, all others 0). The mult/div advances to EX. Next state ST_MD, md_cnt<=MD_LATENCY.
  4. Otherwise: pc_write=1, all others 0.
- ST_MD:
  - Outputs: pc_write=0, if_id_hold=1, id_ex_bubble=1, flush=0.
  - md_cnt decrements each cycle.
  - When md_cnt==1: next state ST_RUN, md_cnt<=0. This gives exactly MD_LATENCY stall cycles.
  - branch_taken asserted in ST_MD is a protocol error. Response: if_id_flush=1 (flush dominates hold); countdown continues unchanged.
  - lu and id_muldiv are ignored in ST_MD.
- Performance counters:
  - perf_stall_cycles increments on every non-reset cycle with pc_write=0.
  - perf_flushes increments on every non-reset cycle with if_id_flush=1.
  - Both saturate at all-ones; no wrap-around.
- Simultaneous lu and id_muldiv in ST_RUN: lu wins. The mult/div is re-evaluated after the 1-cycle stall.
- The ex_rt==0 guard ensures loads to $zero never stall.

Decomposition:
- Package hazard_pkg holds:
  - state encodings ST_RUN=1'b0 and ST_MD=1'b1;
  - REG_ZERO=5'd0;
  - NOP_INSTR=32'h0;
  - default MD_LATENCY.
- One sub-module, sat_counter (parameter W; ports Clk, Reset, inc, count), instantiated twice for the performance counters.

Test Plan:
1. Reset held 3 cycles, then released with all inputs 0 -> during reset pc_write=0, flush=1, bubble=1. After release: pc_write=1, hold=0, flush=0, counters=0.
2. ex_mem_read=1, ex_rt=5'd8, id_rs=5'd8 for one cycle -> pc_write=0, hold=1, bubble=1 that cycle only; perf_stall_cycles=1. Repeat with ex_rt=0 -> no stall.
3. id_muldiv=1 pulse with MD_LATENCY=4 -> issue cycle pc_write=1. Next 4 cycles pc_write=0, hold=1. Then ST_RUN; perf_stall_cycles=4.
4. branch_taken=1 together with lu=1 and id_muldiv=1 -> flush=1, bubble=1, pc_write=1, hold=0. State stays ST_RUN; perf_flushes=1.
5. Reset asserted on the 2nd cycle of an ST_MD stall -> next cycle state=ST_RUN, md_cnt=0, counters=0. With inputs idle, pc_write=1 immediately after reset is released.
6. Force perf_stall_cycles to 16'hFFFE, then apply a 3-cycle stall -> counter reads 16'hFFFF and holds.
